trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the 5-stage pipeline. It accepts illegal-instruction exceptions and mret from decode, plus a level-sensitive external interrupt. It holds the trap CSRs (mstatus, mtvec, mepc, mcause, mtval). It sequences the pipeline through stall, flush and drain, then issues a one-cycle PC redirect to fetch.

---
 rtl/trap_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes decode exceptions, external interrupts and mret,
// owns the trap CSRs, and walks the pipeline through drain and a one-cycle PC redirect.
module trap_ctrl #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  MTVEC_RESET  = 'h0000_0100,
  parameter int unsigned      DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_valid_i,
  input  logic [4:0]       exc_cause_i,
  input  logic [XLEN-1:0]  exc_tval_i,
  input  logic [XLEN-1:0]  dec_pc_i,
  input  logic             mret_valid_i,
  input  logic             irq_i,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [XLEN-1:0]  csr_wdata_i,
  output logic [XLEN-1:0]  csr_rdata_o,
  output logic             stall_f_o,
  output logic             flush_d_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             trap_active_o
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDrain    = 2'd1;
  localparam logic [1:0] StRedirect = 2'd2;

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;
  localparam logic [11:0] AddrMtval   = 12'h343;

  // Counter loads one less than the drain length so that the zero cycle is the last one.
  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

  // Machine external interrupt cause with the interrupt flag in the MSB.
  localparam logic [XLEN-1:0] IrqCause = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic is_idle;
  logic irq_pending;
  logic take_exc;
  logic take_irq;
  logic take_mret;
  logic any_event;
  logic csr_wr;

  // The PC is always word aligned here, so its low bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^dec_pc_i[1:0];

  // Event arbitration: exception beats interrupt beats mret; only accepted in IDLE.
  always_comb begin
    is_idle     = (state_q == StIdle);
    irq_pending = irq_i & mie_q;
    take_exc    = is_idle & exc_valid_i;
    take_irq    = is_idle & ~exc_valid_i & irq_pending;
    take_mret   = is_idle & ~exc_valid_i & ~irq_pending & mret_valid_i;
    any_event   = take_exc | take_irq | take_mret;
    // A trap capture on the same edge wins over a software CSR write.
    csr_wr      = is_idle & ~any_event & csr_we_i;
  end

  // Sequencer next state: IDLE -> DRAIN (counted) -> REDIRECT -> IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (take_exc || take_irq) begin
          state_d  = StDrain;
          cnt_d    = DrainInit;
          target_d = mtvec_q;
        end else if (take_mret) begin
          state_d  = StDrain;
          cnt_d    = DrainInit;
          target_d = mepc_q;
        end
      end
      StDrain: begin
        if (cnt_q == 4'd0) begin
          state_d = StRedirect;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRedirect: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // CSR next state: trap/mret side effects first, otherwise a qualified software write.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    mtval_d  = mtval_q;
    if (take_exc || take_irq) begin
      mepc_d   = {dec_pc_i[XLEN-1:2], 2'b00};
      mcause_d = take_exc ? {{(XLEN-5){1'b0}}, exc_cause_i} : IrqCause;
      mtval_d  = take_exc ? exc_tval_i : '0;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (take_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (csr_addr_i)
        AddrMstatus: begin
          mie_d  = csr_wdata_i[3];
          mpie_d = csr_wdata_i[7];
        end
        AddrMtvec:  mtvec_d  = {csr_wdata_i[XLEN-1:2], 2'b00};
        AddrMepc:   mepc_d   = {csr_wdata_i[XLEN-1:2], 2'b00};
        AddrMcause: mcause_d = csr_wdata_i;
        AddrMtval:  mtval_d  = csr_wdata_i;
        default: ;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Trap CSR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
    end
  end

  // Combinational CSR read mux; unmapped addresses read zero.
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      AddrMstatus: begin
        csr_rdata_o[3] = mie_q;
        csr_rdata_o[7] = mpie_q;
      end
      AddrMtvec:  csr_rdata_o = mtvec_q;
      AddrMepc:   csr_rdata_o = mepc_q;
      AddrMcause: csr_rdata_o = mcause_q;
      AddrMtval:  csr_rdata_o = mtval_q;
      default: ;
    endcase
  end

  // Moore pipeline controls decoded from the sequencer state only.
  always_comb begin
    stall_f_o        = (state_q == StDrain);
    flush_d_o        = (state_q == StDrain) || (state_q == StRedirect);
    redirect_valid_o = (state_q == StRedirect);
    redirect_pc_o    = (state_q == StRedirect) ? target_q : '0;
    trap_active_o    = (state_q != StIdle);
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios, a cycle-phase reference model compared every
// cycle, and literal spot checks that pin the model.
module tb_trap_ctrl;
  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_tval;
  logic [31:0] dec_pc;
  logic        mret_valid;
  logic        irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        stall_f;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_active;

  trap_ctrl #(
    .XLEN         (32),
    .MTVEC_RESET  (32'h0000_0100),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .exc_valid_i      (exc_valid),
    .exc_cause_i      (exc_cause),
    .exc_tval_i       (exc_tval),
    .dec_pc_i         (dec_pc),
    .mret_valid_i     (mret_valid),
    .irq_i            (irq),
    .csr_we_i         (csr_we),
    .csr_addr_i       (csr_addr),
    .csr_wdata_i      (csr_wdata),
    .csr_rdata_o      (csr_rdata),
    .stall_f_o        (stall_f),
    .flush_d_o        (flush_d),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .trap_active_o    (trap_active)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int redir_cnt = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase counts cycles since the accepted event
  // (0 idle, 1..D draining, D+1 redirecting).
  int          phase;
  logic [31:0] m_ms, m_tvec, m_epc, m_cause, m_tval, m_tgt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 0; m_ms <= 0; m_tvec <= 32'h100; m_epc <= 0; m_cause <= 0; m_tval <= 0;
      m_tgt <= 0;
    end else if (phase == 0) begin
      if (exc_valid || (irq && m_ms[3])) begin
        phase   <= 1;
        m_epc   <= dec_pc & 32'hFFFF_FFFC;
        m_cause <= exc_valid ? {27'd0, exc_cause} : 32'h8000_000B;
        m_tval  <= exc_valid ? exc_tval : 32'd0;
        m_ms    <= m_ms[3] ? 32'h80 : 32'h0;
        m_tgt   <= m_tvec;
      end else if (mret_valid) begin
        phase <= 1;
        m_ms  <= 32'h80 | (m_ms[7] ? 32'h8 : 32'h0);
        m_tgt <= m_epc;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: m_ms    <= csr_wdata & 32'h88;
          12'h305: m_tvec  <= csr_wdata & 32'hFFFF_FFFC;
          12'h341: m_epc   <= csr_wdata & 32'hFFFF_FFFC;
          12'h342: m_cause <= csr_wdata;
          12'h343: m_tval  <= csr_wdata;
          default: ;
        endcase
      end
    end else if (phase == D + 1) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_ms;
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      default: return 32'h0;
    endcase
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      chk("stall_f",        32'(stall_f),        32'(phase >= 1 && phase <= D));
      chk("flush_d",        32'(flush_d),        32'(phase >= 1));
      chk("redirect_valid", 32'(redirect_valid), 32'(phase == D + 1));
      chk("redirect_pc",    redirect_pc,         (phase == D + 1) ? m_tgt : 32'h0);
      chk("trap_active",    32'(trap_active),    32'(phase != 0));
      chk("csr_rdata",      csr_rdata,           m_read(csr_addr));
    end
  end

  always @(negedge clk) begin
    if (redirect_valid === 1'b1) redir_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string name, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    step(1);
    csr_we = 1'b0;
  endtask

  int r0;

  initial begin
    rst = 1'b1; exc_valid = 0; exc_cause = 0; exc_tval = 0; dec_pc = 0; mret_valid = 0;
    irq = 0; csr_we = 0; csr_addr = 12'h305; csr_wdata = 0;
    step(2);
    run = 1'b1;
    chk("rst_mtvec", csr_rdata, 32'h100);
    chk("rst_active", 32'(trap_active), 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    step(1);

    // Illegal opcode exception.
    exc_valid = 1; exc_cause = 5'd2; exc_tval = 32'h7F; dec_pc = 32'h40;
    step(1);
    exc_valid = 0;
    chk("s1_drain1_stall", 32'(stall_f), 32'h1);
    chk("s1_drain1_flush", 32'(flush_d), 32'h1);
    step(1);
    chk("s1_drain2_stall", 32'(stall_f), 32'h1);
    step(1);
    chk("s1_redir_valid", 32'(redirect_valid), 32'h1);
    chk("s1_redir_pc", redirect_pc, 32'h100);
    chk("s1_redir_stall", 32'(stall_f), 32'h0);
    chk("s1_redir_flush", 32'(flush_d), 32'h1);
    step(1);
    chk("s1_idle", 32'(trap_active), 32'h0);
    rd(12'h341, "s1_mepc", 32'h40);
    rd(12'h342, "s1_mcause", 32'h2);
    rd(12'h343, "s1_mtval", 32'h7F);

    // mret round trip back to the faulting PC.
    mret_valid = 1;
    step(1);
    mret_valid = 0;
    chk("s3_active", 32'(trap_active), 32'h1);
    step(2);
    chk("s3_redir_valid", 32'(redirect_valid), 32'h1);
    chk("s3_redir_pc", redirect_pc, 32'h40);
    step(1);
    rd(12'h300, "s3_mstatus", 32'h80);

    // Interrupt masked, then enabled by a mstatus write.
    irq = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("s2_masked", 32'(trap_active), 32'h0);
    end
    wr(12'h300, 32'h8);
    rd(12'h300, "s2_mie_set", 32'h8);
    step(1);
    irq = 0;
    chk("s2_taken", 32'(trap_active), 32'h1);
    rd(12'h342, "s2_mcause", 32'h8000_000B);
    rd(12'h343, "s2_mtval", 32'h0);
    rd(12'h300, "s2_mstatus", 32'h80);
    step(3);

    // Everything on one edge: exception wins, mtvec write dropped, DRAIN pulse ignored.
    wr(12'h300, 32'h8);
    exc_valid = 1; exc_cause = 5'd2; exc_tval = 32'h11; dec_pc = 32'h86;
    irq = 1; mret_valid = 1; csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h200;
    step(1);
    exc_valid = 0; irq = 0; mret_valid = 0; csr_we = 0;
    chk("s4_active", 32'(trap_active), 32'h1);
    exc_valid = 1; exc_cause = 5'd5;
    step(1);
    exc_valid = 0;
    rd(12'h342, "s4_mcause", 32'h2);
    rd(12'h305, "s4_mtvec", 32'h100);
    rd(12'h341, "s4_mepc", 32'h84);
    rd(12'h300, "s4_mstatus", 32'h80);
    step(1);
    chk("s4_redir_pc", redirect_pc, 32'h100);
    step(1);
    chk("s4_idle", 32'(trap_active), 32'h0);

    // CSR write masking and unmapped addresses.
    wr(12'h343, 32'hFFFF_FFFF);
    rd(12'h343, "s5_mtval", 32'hFFFF_FFFF);
    wr(12'h305, 32'hFFFF_FFFF);
    rd(12'h305, "s5_mtvec", 32'hFFFF_FFFC);
    wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, "s5_mstatus", 32'h88);
    wr(12'h7C0, 32'h1234);
    rd(12'h7C0, "s5_unmapped", 32'h0);

    // Async reset in DRAIN abandons the trap.
    r0 = redir_cnt;
    exc_valid = 1; exc_cause = 5'd3; dec_pc = 32'h100;
    step(1);
    exc_valid = 0;
    chk("s6_active", 32'(trap_active), 32'h1);
    rst = 1'b1;
    #1;
    chk("s6_stall", 32'(stall_f), 32'h0);
    chk("s6_flush", 32'(flush_d), 32'h0);
    chk("s6_active_rst", 32'(trap_active), 32'h0);
    chk("s6_redir", 32'(redirect_valid), 32'h0);
    step(3);
    rst = 1'b0;
    step(6);
    chk("s6_no_redirect", redir_cnt, r0);
    rd(12'h305, "s6_mtvec", 32'h100);
    rd(12'h300, "s6_mstatus", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
